mddr_phy_io: RTL and testbench

MDDR_PHY_IO -- requirements
Module: mddr_phy_io

---
 rtl/mddr_phy_io.sv | 182 ++++++++++++++++++
 tb/tb_mddr_phy_io.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mddr_phy_io.sv
// mddr_phy_io: pad sequencer for DDR-style write/read bursts with a fixed bus turnaround after each burst.
// Define MDDR_PHY_IO_DQS_CHECK_EN to build the read-strobe parity check that drives rd_err_o.
module mddr_phy_io #(
   parameter int DQ_W      = 16,
   parameter int BURST_LEN = 4,
   parameter int CAS_LAT   = 3,
   parameter int TURN_CYC  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_wr_i,
   input  logic [DQ_W-1:0]       wr_data_i,
   input  logic [DQ_W/8-1:0]     wr_mask_i,
   output logic                  wr_data_req_o,
   output logic [DQ_W-1:0]       rd_data_o,
   output logic                  rd_valid_o,
   output logic [DQ_W-1:0]       dq_o,
   input  logic [DQ_W-1:0]       dq_i,
   output logic                  dq_oe_o,
   output logic [DQ_W/8-1:0]     dm_o,
   output logic [DQ_W/8-1:0]     dqs_o,
   input  logic [DQ_W/8-1:0]     dqs_i,
   output logic                  dqs_oe_o,
   output logic                  rd_err_o
);

   localparam int LANES   = DQ_W / 8;
   localparam int MAX_BT  = (BURST_LEN > TURN_CYC) ? BURST_LEN : TURN_CYC;
   localparam int CNT_MAX = (MAX_BT > CAS_LAT) ? MAX_BT : CAS_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WPRE  = 3'd1,
      WDATA = 3'd2,
      WPOST = 3'd3,
      RWAIT = 3'd4,
      RDATA = 3'd5,
      TURN  = 3'd6
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ready_q;
   logic               oe_q;
   logic [LANES-1:0]   dqs_q;
   logic               rd_vld_q;
   logic [DQ_W-1:0]    rd_data_q;

   // One counter serves every timed state; it restarts from 0 on each state entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         oe_q      <= 1'b0;
         dqs_q     <= '0;
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid_i) begin
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  if (cmd_wr_i) begin
                     state_q <= WPRE;
                     oe_q    <= 1'b1;
                     dqs_q   <= '0;
                  end else begin
                     state_q <= RWAIT;
                  end
               end
            end
            WPRE: begin
               state_q <= WDATA;
               cnt_q   <= '0;
               dqs_q   <= '1;
            end
            WDATA: begin
               if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                  state_q <= WPOST;
                  dqs_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  // Next beat index is cnt_q+1: even (strobe high) exactly when cnt_q is odd.
                  dqs_q <= {LANES{cnt_q[0]}};
               end
            end
            WPOST: begin
               state_q <= TURN;
               cnt_q   <= '0;
               oe_q    <= 1'b0;
            end
            RWAIT: begin
               if (cnt_q == CNT_W'(CAS_LAT - 2)) begin
                  state_q <= RDATA;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RDATA: begin
               rd_data_q <= dq_i;
               rd_vld_q  <= 1'b1;
               if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                  state_q <= TURN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            TURN: begin
               if (cnt_q == CNT_W'(TURN_CYC - 1)) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               oe_q    <= 1'b0;
               dqs_q   <= '0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   logic wdata_act;
   assign wdata_act = (state_q == WDATA);

   assign cmd_ready_o   = ready_q;
   assign wr_data_req_o = wdata_act;
   assign dq_o          = wdata_act ? wr_data_i : '0;
   assign dm_o          = wdata_act ? wr_mask_i : '0;
   assign dq_oe_o       = oe_q;
   assign dqs_oe_o      = oe_q;
   assign dqs_o         = dqs_q;
   assign rd_valid_o    = rd_vld_q;
   assign rd_data_o     = rd_data_q;

`ifdef MDDR_PHY_IO_DQS_CHECK_EN
   logic err_q;
   logic err_d;
   logic rd_accept;
   logic dqs_bad;

   // Expected read strobe is high on even beats; every lane is checked independently.
   always_comb begin
      rd_accept = (state_q == IDLE) && cmd_valid_i && !cmd_wr_i;
      dqs_bad   = (state_q == RDATA) && (dqs_i != {LANES{~cnt_q[0]}});
      err_d     = err_q;
      if (rd_accept) begin
         err_d = 1'b0;
      end else if (dqs_bad) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign rd_err_o = err_q;
`else
   logic dqs_unused;
   assign dqs_unused = ^dqs_i;
   assign rd_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mddr_phy_io.sv
// tb_mddr_phy_io: drives directed and random write/read bursts and checks every output each cycle
// against a timeline model derived from the burst/turnaround rules.
module tb_mddr_phy_io;

   localparam int DQ_W   = 16;
   localparam int LANES  = DQ_W / 8;
   localparam int BL     = 4;
   localparam int CL     = 3;
   localparam int TC     = 2;
   localparam int WR_LEN = BL + 2 + TC;
   localparam int RD_LEN = CL - 1 + BL + TC;
`ifdef MDDR_PHY_IO_DQS_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic              cmd_wr_i;
   logic [DQ_W-1:0]   wr_data_i;
   logic [LANES-1:0]  wr_mask_i;
   logic              wr_data_req_o;
   logic [DQ_W-1:0]   rd_data_o;
   logic              rd_valid_o;
   logic [DQ_W-1:0]   dq_o;
   logic [DQ_W-1:0]   dq_i;
   logic              dq_oe_o;
   logic [LANES-1:0]  dm_o;
   logic [LANES-1:0]  dqs_o;
   logic [LANES-1:0]  dqs_i;
   logic              dqs_oe_o;
   logic              rd_err_o;

   mddr_phy_io #(.DQ_W(DQ_W), .BURST_LEN(BL), .CAS_LAT(CL), .TURN_CYC(TC)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
      .wr_data_i(wr_data_i), .wr_mask_i(wr_mask_i), .wr_data_req_o(wr_data_req_o),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .dq_o(dq_o), .dq_i(dq_i), .dq_oe_o(dq_oe_o),
      .dm_o(dm_o), .dqs_o(dqs_o), .dqs_i(dqs_i), .dqs_oe_o(dqs_oe_o),
      .rd_err_o(rd_err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   logic [DQ_W-1:0]  wdat [BL];
   logic [LANES-1:0] wmsk [BL];
   logic [DQ_W-1:0]  rdat [BL];
   int               bad_beat;
   int               bad_lane;
   logic             dqs_mis;
   logic [DQ_W-1:0]  exp_rd;
   logic             exp_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // k counts cycles after the accept cycle (accept = 0); busy=0 means an idle cycle.
   task automatic check_cycle(input bit busy, input bit wr, input int k);
      bit wwin, wdata, rvld;
      wwin  = busy && wr && (k >= 1) && (k <= BL + 2);
      wdata = busy && wr && (k >= 2) && (k <= BL + 1);
      rvld  = busy && !wr && (k >= CL + 1) && (k <= CL + BL);
      chk("cmd_ready", 64'(cmd_ready_o), 64'(!busy));
      chk("dq_oe", 64'(dq_oe_o), 64'(wwin));
      chk("dqs_oe", 64'(dqs_oe_o), 64'(wwin));
      chk("wr_data_req", 64'(wr_data_req_o), 64'(wdata));
      if (wdata) begin
         chk("dq_o", 64'(dq_o), 64'(wdat[k-2]));
         chk("dm_o", 64'(dm_o), 64'(wmsk[k-2]));
         chk("dqs_o", 64'(dqs_o), ((k - 2) % 2 == 0) ? 64'({LANES{1'b1}}) : 64'(0));
      end else begin
         chk("dq_o_idle", 64'(dq_o), 64'(0));
         chk("dm_o_idle", 64'(dm_o), 64'(0));
         chk("dqs_o_idle", 64'(dqs_o), 64'(0));
      end
      chk("rd_valid", 64'(rd_valid_o), 64'(rvld));
      if (rvld) exp_rd = rdat[k-CL-1];
      chk("rd_data", 64'(rd_data_o), 64'(exp_rd));
      chk("rd_err", 64'(rd_err_o), 64'(exp_err));
   endtask

   task automatic drive_data(input bit busy, input bit wr, input int k);
      logic [LANES-1:0] par;
      int b;
      if (busy && wr && k >= 2 && k <= BL + 1) begin
         wr_data_i = wdat[k-2];
         wr_mask_i = wmsk[k-2];
      end else begin
         wr_data_i = DQ_W'($urandom);
         wr_mask_i = LANES'($urandom);
      end
      dqs_mis = 1'b0;
      if (busy && !wr && k >= CL && k < CL + BL) begin
         b = k - CL;
         dq_i = rdat[b];
         par = (b % 2 == 0) ? {LANES{1'b1}} : {LANES{1'b0}};
         if (b == bad_beat) begin
            par[bad_lane] = ~par[bad_lane];
            dqs_mis = 1'b1;
         end
         dqs_i = par;
      end else begin
         dq_i  = DQ_W'($urandom);
         dqs_i = LANES'($urandom);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < BL; i++) begin
         wdat[i] = DQ_W'($urandom);
         wmsk[i] = LANES'($urandom);
         rdat[i] = DQ_W'($urandom);
      end
      bad_beat = -1;
      bad_lane = 0;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the burst (or after reset abort).
   task automatic run_txn(input bit wr, input int gap, input int abort_at);
      int len;
      len = wr ? WR_LEN : RD_LEN;
      for (int g = 0; g < gap; g++) begin
         cmd_valid_i = 1'b0;
         cmd_wr_i    = 1'($urandom);
         drive_data(1'b0, 1'b0, 0);
         @(negedge clk_i);
         check_cycle(1'b0, 1'b0, 0);
         @(posedge clk_i); #1;
      end
      cmd_valid_i = 1'b1;
      cmd_wr_i    = wr;
      drive_data(1'b0, 1'b0, 0);
      @(negedge clk_i);
      check_cycle(1'b0, 1'b0, 0);
      @(posedge clk_i);
      if (CHK_EN && !wr) exp_err = 1'b0;
      #1;
      for (int k = 1; k <= len; k++) begin
         rst_i       = (k == abort_at);
         cmd_valid_i = 1'($urandom);
         cmd_wr_i    = 1'($urandom);
         drive_data(1'b1, wr, k);
         @(negedge clk_i);
         check_cycle(1'b1, wr, k);
         @(posedge clk_i);
         if (CHK_EN && dqs_mis) exp_err = 1'b1;
         if (k == abort_at) begin
            exp_rd  = '0;
            exp_err = 1'b0;
            #1;
            rst_i       = 1'b0;
            cmd_valid_i = 1'b0;
            return;
         end
         #1;
      end
      cmd_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i       = 1'b1;
      cmd_valid_i = 1'b1;
      cmd_wr_i    = 1'b1;
      wr_data_i   = '0;
      wr_mask_i   = '0;
      dq_i        = '0;
      dqs_i       = '0;
      exp_rd      = '0;
      exp_err     = 1'b0;
      bad_beat    = -1;
      bad_lane    = 0;
      dqs_mis     = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check_cycle(1'b0, 1'b0, 0);
      @(posedge clk_i); #1;
      rst_i       = 1'b0;
      cmd_valid_i = 1'b0;

      fill_random();
      for (int i = 0; i < BL; i++) wdat[i] = DQ_W'(16'h1111 * (i + 1));
      run_txn(1'b1, 1, 0);

      fill_random();
      rdat[0] = 16'hA0A0; rdat[1] = 16'hB0B0; rdat[2] = 16'hC0C0; rdat[3] = 16'hD0D0;
      run_txn(1'b0, 1, 0);

      fill_random();
      run_txn(1'b1, 0, 0);
      fill_random();
      run_txn(1'b0, 0, 0);

      fill_random();
      run_txn(1'b1, 2, 3);

      fill_random();
      bad_beat = 0;
      bad_lane = 1;
      run_txn(1'b0, 1, 0);
      fill_random();
      run_txn(1'b1, 0, 0);
      fill_random();
      run_txn(1'b0, 1, 0);

      fill_random();
      run_txn(1'b0, 1, CL + 1);

      for (int t = 0; t < 60; t++) begin
         bit wr;
         int ab;
         fill_random();
         wr = 1'($urandom);
         if ($urandom % 4 == 0) begin
            bad_beat = int'($urandom % BL);
            bad_lane = int'($urandom % LANES);
         end
         ab = ($urandom % 12 == 0) ? int'($urandom_range(1, wr ? WR_LEN : RD_LEN)) : 0;
         run_txn(wr, int'($urandom % 4), ab);
      end

      fill_random();
      run_txn(1'b1, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
